// File: rtl/traffic_scheduler_if.sv
// Frame-control inputs and VGA-side car position bus for traffic_scheduler.
// The slave modport is the scheduler; master is the game/timing side.
interface traffic_scheduler_if;
   logic       frame_tick;
   logic       pause;
   logic [3:0] current_level;
   logic [9:0] frog_x;
   logic [9:0] frog_y;
   logic [9:0] car_x_0, car_x_1, car_x_2, car_x_3;
   logic [9:0] car_x_4, car_x_5, car_x_6, car_x_7;
   logic [9:0] car_y_0, car_y_1, car_y_2, car_y_3;
   logic [9:0] car_y_4, car_y_5, car_y_6, car_y_7;
   logic       busy;
   logic       update_done;
   logic       hit;

   modport slave (
      input  frame_tick, pause, current_level, frog_x, frog_y,
      output car_x_0, car_x_1, car_x_2, car_x_3,
      output car_x_4, car_x_5, car_x_6, car_x_7,
      output car_y_0, car_y_1, car_y_2, car_y_3,
      output car_y_4, car_y_5, car_y_6, car_y_7,
      output busy, update_done, hit
   );

   modport master (
      output frame_tick, pause, current_level, frog_x, frog_y,
      input  car_x_0, car_x_1, car_x_2, car_x_3,
      input  car_x_4, car_x_5, car_x_6, car_x_7,
      input  car_y_0, car_y_1, car_y_2, car_y_3,
      input  car_y_4, car_y_5, car_y_6, car_y_7,
      input  busy, update_done, hit
   );
endinterface

// File: rtl/traffic_scheduler.sv
// Per-frame car position sweep through one shared adder/wrap unit.
// Optional frog collision check enabled by TRAFFIC_COLLIDE_EN.
module traffic_scheduler #(
   parameter int H_WRAP       = 640,
   parameter int BASE_SPEED   = 2,
   parameter int LANE_Y0      = 64,
   parameter int LANE_PITCH   = 48,
   parameter int INIT_SPACING = 80,
   parameter int CAR_SIZE     = 32
) (
   input logic clk,
   input logic rst_n,
   traffic_scheduler_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE,
      SWEEP,
      DONE
   } state_t;

   state_t     state;
   logic [2:0] idx;
   logic [3:0] lvl_q;
   logic [9:0] car_x [8];
   logic       busy_q;
   logic       done_q;

   logic [5:0]  spd;
   logic [9:0]  cur;
   logic [10:0] sum;
   logic        active;
   logic [9:0]  nx;
   logic        start;

   assign start  = (state == IDLE) && bus.frame_tick && !bus.pause;
   assign spd    = 6'(BASE_SPEED) + {2'b00, lvl_q};
   assign cur    = car_x[idx];
   assign sum    = {1'b0, cur} + {5'b0, spd};
   assign active = ({1'b0, idx} < lvl_q);

   // Even lanes run right, odd lanes run left; parked lanes reload home x.
   always_comb begin
      nx = 10'(idx * INIT_SPACING);
      if (active) begin
         if (!idx[0]) begin
            if (sum >= 11'(H_WRAP))
               nx = 10'(sum - 11'(H_WRAP));
            else
               nx = sum[9:0];
         end else begin
            if (cur < {4'b0, spd})
               nx = cur + 10'(H_WRAP) - {4'b0, spd};
            else
               nx = cur - {4'b0, spd};
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         idx    <= '0;
         lvl_q  <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
         for (int i = 0; i < 8; i++)
            car_x[i] <= 10'(i * INIT_SPACING);
      end else begin
         unique case (state)
            IDLE: begin
               done_q <= 1'b0;
               if (start) begin
                  state  <= SWEEP;
                  lvl_q  <= bus.current_level;
                  idx    <= '0;
                  busy_q <= 1'b1;
               end
            end
            SWEEP: begin
               car_x[idx] <= nx;
               idx        <= idx + 3'd1;
               if (idx == 3'd7) begin
                  state  <= DONE;
                  done_q <= 1'b1;
               end
            end
            DONE: begin
               state  <= IDLE;
               done_q <= 1'b0;
               busy_q <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef TRAFFIC_COLLIDE_EN
   logic        hit_acc;
   logic        hit_q;
   logic        olap;
   logic [10:0] ly;

   assign ly = 11'(LANE_Y0) + 11'(idx * LANE_PITCH);

   always_comb begin
      olap = ({1'b0, nx} < {1'b0, bus.frog_x} + 11'd32)
          && ({1'b0, bus.frog_x} < {1'b0, nx} + 11'(CAR_SIZE))
          && (ly < {1'b0, bus.frog_y} + 11'd32)
          && ({1'b0, bus.frog_y} < ly + 11'(CAR_SIZE));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hit_acc <= 1'b0;
         hit_q   <= 1'b0;
      end else begin
         if (start)
            hit_acc <= 1'b0;
         else if (state == SWEEP && active && olap)
            hit_acc <= 1'b1;
         if (state == DONE)
            hit_q <= hit_acc;
      end
   end

   assign bus.hit = hit_q;
`else
   logic unused_frog;
   assign unused_frog = ^{bus.frog_x, bus.frog_y};
   assign bus.hit = 1'b0;
`endif

   assign bus.busy        = busy_q;
   assign bus.update_done = done_q;

   assign bus.car_x_0 = car_x[0];
   assign bus.car_x_1 = car_x[1];
   assign bus.car_x_2 = car_x[2];
   assign bus.car_x_3 = car_x[3];
   assign bus.car_x_4 = car_x[4];
   assign bus.car_x_5 = car_x[5];
   assign bus.car_x_6 = car_x[6];
   assign bus.car_x_7 = car_x[7];

   assign bus.car_y_0 = 10'(LANE_Y0 + 0 * LANE_PITCH);
   assign bus.car_y_1 = 10'(LANE_Y0 + 1 * LANE_PITCH);
   assign bus.car_y_2 = 10'(LANE_Y0 + 2 * LANE_PITCH);
   assign bus.car_y_3 = 10'(LANE_Y0 + 3 * LANE_PITCH);
   assign bus.car_y_4 = 10'(LANE_Y0 + 4 * LANE_PITCH);
   assign bus.car_y_5 = 10'(LANE_Y0 + 5 * LANE_PITCH);
   assign bus.car_y_6 = 10'(LANE_Y0 + 6 * LANE_PITCH);
   assign bus.car_y_7 = 10'(LANE_Y0 + 7 * LANE_PITCH);

endmodule
